// File: rtl/conv_stream_pkg.sv
// Shared types and helpers for the conv_2D stream source.
// CONV_SRC_GAP_EN adds a kernel-end tag to each beat (used for the phase bubble).
package conv_stream_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
`ifdef CONV_SRC_GAP_EN
    logic              kl;
`endif
  } beat_t;

  function automatic int conv_total(input int x, input int h);
    return h * h + x * x;
  endfunction

endpackage

// File: rtl/conv_src_ram.sv
// Simple dual-port byte RAM: host write port, registered transmitter read port.
module conv_src_ram
  import conv_stream_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv_stream_src.sv
// Replays a preloaded kernel+image buffer as a valid/ready byte stream for conv_2D.
// Optional macro CONV_SRC_GAP_EN: one idle cycle between the last kernel beat and the image.
module conv_stream_src
  import conv_stream_pkg::*;
#(
  parameter int X  = 5,
  parameter int H  = 3,
  parameter int AW = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_wr_en,
  input  logic [AW-1:0]     host_addr,
  input  logic [BYTE_W-1:0] host_data,
  input  logic              start,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int N = conv_total(X, H);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  if (N > (1 << AW)) begin : g_n_check
    $error("conv_stream_src: H*H+X*X exceeds 2**AW");
  end

  state_t            state, state_nxt;
  logic [AW-1:0]     rd_ptr;
  logic              all_iss;
  logic              pend, pend_last;
  logic [BYTE_W-1:0] rd_data;
  logic [1:0]        cnt, occ;
  beat_t             e0, e1, in_beat;
  logic              issue, push, pop;

  conv_src_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (host_wr_en && state == IDLE),
    .wr_addr (host_addr),
    .wr_data (host_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Reads are only issued when the 2-entry skid is guaranteed room for the returning byte.
  assign push  = pend;
  assign pop   = m_valid && m_ready;
  assign occ   = cnt + {1'b0, pend} - {1'b0, pop};
  assign issue = (state == FETCH || state == SEND) && !all_iss && (occ < 2'd2);

`ifdef CONV_SRC_GAP_EN
  localparam logic [AW-1:0] KL_ADDR = AW'(H * H - 1);
  logic pend_kl, gap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_kl <= 1'b0;
      gap     <= 1'b0;
    end else begin
      pend_kl <= issue && (rd_ptr == KL_ADDR);
      gap     <= pop && e0.kl;
    end
  end

  assign m_valid = (cnt != 2'd0) && !gap;
`else
  assign m_valid = (cnt != 2'd0);
`endif

  assign m_data = e0.data;
  assign m_last = m_valid && e0.last;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_comb begin
    in_beat      = '0;
    in_beat.data = rd_data;
    in_beat.last = pend_last;
`ifdef CONV_SRC_GAP_EN
    in_beat.kl   = pend_kl;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND:    if (pop && e0.last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      all_iss   <= 1'b0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      cnt       <= 2'd0;
      e0        <= '0;
      e1        <= '0;
    end else begin
      state     <= state_nxt;
      pend      <= issue;
      pend_last <= issue && (rd_ptr == LAST_ADDR);
      if (state == IDLE && start) begin
        rd_ptr  <= '0;
        all_iss <= 1'b0;
      end else if (issue) begin
        // Pointer parks on N-1; the flag stops further reads.
        if (rd_ptr == LAST_ADDR) all_iss <= 1'b1;
        else                     rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= in_beat;
          else             e1 <= in_beat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) e0 <= in_beat;
          else begin
            e0 <= e1;
            e1 <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_src.sv
// Scoreboard bench for conv_stream_src: default (H=3,X=5) and minimal (H=1,X=1) instances.
module tb_conv_stream_src;

  localparam int AW = 14;
`ifdef CONV_SRC_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic wr_a = 0, wr_b = 0, start_a = 0, start_b = 0, m_ready = 0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_data = '0;

  logic [7:0] a_data, b_data;
  logic a_valid, a_last, a_busy, a_done, b_valid, b_last, b_busy, b_done;

  conv_stream_src #(.X(5), .H(3), .AW(AW)) dut_a (
    .clk(clk), .reset(reset), .host_wr_en(wr_a), .host_addr(host_addr), .host_data(host_data),
    .start(start_a), .m_data(a_data), .m_valid(a_valid), .m_ready(m_ready), .m_last(a_last),
    .busy(a_busy), .done(a_done));

  conv_stream_src #(.X(1), .H(1), .AW(AW)) dut_b (
    .clk(clk), .reset(reset), .host_wr_en(wr_b), .host_addr(host_addr), .host_data(host_data),
    .start(start_b), .m_data(b_data), .m_valid(b_valid), .m_ready(m_ready), .m_last(b_last),
    .busy(b_busy), .done(b_done));

  logic sel = 1'b0;
  logic [7:0] mon_data;
  logic mon_valid, mon_last, mon_busy, mon_done;
  assign mon_data  = sel ? b_data  : a_data;
  assign mon_valid = sel ? b_valid : a_valid;
  assign mon_last  = sel ? b_last  : a_last;
  assign mon_busy  = sel ? b_busy  : a_busy;
  assign mon_done  = sel ? b_done  : a_done;

  typedef struct { logic [7:0] data; logic last; } beat_t;
  beat_t exp_q[$];

  int n_vec = 0, n_bad = 0, cyc = 0, ready_mode = 0;
  int beats_seen = 0, first_cyc = 0, last_cyc = 0, bubbles = 0;
  bit got_first = 0, got_last = 0, prev_stall = 0;
  logic [7:0] prev_data;
  logic prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: a beat present with m_ready high at the falling edge transfers on the next rising edge.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (prev_stall)
      chk("stall_hold", {mon_valid, mon_last, mon_data}, {1'b1, prev_last, prev_data});
    prev_stall = 0;
    if (got_first && !got_last && !mon_valid) bubbles++;
    if (mon_valid && m_ready) begin
      beats_seen++;
      if (!got_first) begin
        got_first = 1;
        first_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_beat: got 0x%0h with empty scoreboard", mon_data);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("beat%0d", beats_seen), {mon_last, mon_data}, {e.last, e.data});
      end
      if (mon_last) begin
        got_last = 1;
        last_cyc = cyc;
      end
    end else if (mon_valid) begin
      prev_stall = 1;
      prev_data  = mon_data;
      prev_last  = mon_last;
    end
  end

  task automatic wr(input bit s, input int a, input int d);
    @(posedge clk);
    #1;
    host_addr = AW'(a);
    host_data = 8'(d);
    if (s) wr_b = 1; else wr_a = 1;
    @(posedge clk);
    #1;
    wr_a = 0;
    wr_b = 0;
  endtask

  task automatic clear_mon();
    beats_seen = 0; got_first = 0; got_last = 0; bubbles = 0; prev_stall = 0;
  endtask

  task automatic push_exp(input bit s);
    beat_t e;
    if (s) begin
      e.data = 8'hA5; e.last = 0; exp_q.push_back(e);
      e.data = 8'h5A; e.last = 1; exp_q.push_back(e);
    end else begin
      for (int i = 0; i < 34; i++) begin
        e.data = 8'(i + 1);
        e.last = (i == 33);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input bit s);
    @(posedge clk);
    #1;
    if (s) start_b = 1; else start_a = 1;
    @(posedge clk);
    #1;
    start_a = 0;
    start_b = 0;
  endtask

  task automatic run(input bit s, input int mode, input bit inject, input string tag);
    int n, t;
    n = s ? 2 : 34;
    sel = s;
    clear_mon();
    push_exp(s);
    ready_mode = mode;
    pulse_start(s);
    @(negedge clk);
    chk({tag, "_busy_fetch"}, mon_busy, 1);
    chk({tag, "_valid_fetch"}, mon_valid, 0);
    @(negedge clk);
    chk({tag, "_valid_e1"}, mon_valid, 0);
    @(negedge clk);
    chk({tag, "_valid_e2"}, mon_valid, 1);
    if (inject) begin
      @(posedge clk);
      #1;
      start_a = 1; wr_a = 1; host_addr = AW'(3); host_data = 8'hFF;
      @(posedge clk);
      #1;
      start_a = 0; wr_a = 0;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mon_done && t < 500);
    chk({tag, "_done_seen"}, mon_done, 1);
    chk({tag, "_done_timing"}, cyc - last_cyc, 1);
    chk({tag, "_beats"}, beats_seen, n);
    chk({tag, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, mon_done, 0);
    chk({tag, "_busy_after"}, mon_busy, 0);
    if (mode == 0) begin
      chk({tag, "_span"}, last_cyc - first_cyc, n - 1 + GAP);
      chk({tag, "_bubbles"}, bubbles, GAP);
    end
  endtask

  task automatic reset_mid();
    int t;
    sel = 0;
    clear_mon();
    push_exp(0);
    ready_mode = 0;
    pulse_start(0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (beats_seen < 10 && t < 200);
    chk("rst_reached_beat10", beats_seen >= 10, 1);
    #1 reset = 0;
    #1;
    chk("rst_valid", a_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_last", a_last, 0);
    chk("rst_data", a_data, 0);
    exp_q.delete();
    @(posedge clk);
    #3 reset = 1;
  endtask

  initial begin
    #3;
    chk("reset_a_valid", a_valid, 0);
    chk("reset_a_last", a_last, 0);
    chk("reset_a_data", a_data, 0);
    chk("reset_a_busy", a_busy, 0);
    chk("reset_a_done", a_done, 0);
    chk("reset_b_valid", b_valid, 0);
    chk("reset_b_busy", b_busy, 0);
    chk("reset_b_done", b_done, 0);
    #10 reset = 1;
    for (int i = 0; i < 34; i++) wr(0, i, i + 1);
    run(0, 0, 0, "t1");
    run(0, 1, 0, "t2");
    run(0, 1, 1, "t3");
    run(0, 0, 0, "t3b");
    reset_mid();
    run(0, 0, 0, "t4");
    wr(1, 0, 8'hA5);
    wr(1, 1, 8'h5A);
    run(1, 0, 0, "t5");
    run(1, 1, 0, "t5b");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
